// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with an iterative restoring divider for DIV/MOD.
// Latency: 1 cycle for every op except DIV/MOD with B!=0, which take DATAWIDTH+1 cycles.
// Backpressure: Busy is high while a division iterates; Enable is ignored (not queued) then.
//
// Ports:
//   CLK, RST         clock (rising edge) and asynchronous active-low reset
//   A, B             unsigned operands, DATAWIDTH bits
//   ALU_FUNC         opcode, sampled together with Enable
//   Enable           request strobe, accepted only when Busy=0
//   Busy             registered, high while the divider iterates
//   ALU_OUT          registered 2*DATAWIDTH result, holds between results
//   OUT_VALID        one-cycle pulse when ALU_OUT updates
//   DIV_ERR          qualifies the pulse: DIV/MOD with B=0, or divider not built
//
// Build option: define ALU_DIV_EN to build the iterative divider. Without it,
// DIV/MOD finish in one cycle with ALU_OUT=0 and DIV_ERR=1, and Busy is tied low.
module alu_seq #(
  parameter int DATAWIDTH = 8,
  parameter int FUNC      = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATAWIDTH-1:0]   A,
  input  logic [DATAWIDTH-1:0]   B,
  input  logic [FUNC-1:0]        ALU_FUNC,
  input  logic                   Enable,
  output logic                   Busy,
  output logic [2*DATAWIDTH-1:0] ALU_OUT,
  output logic                   OUT_VALID,
  output logic                   DIV_ERR
);

  localparam int W  = DATAWIDTH;
  localparam int OW = 2 * DATAWIDTH;

  localparam logic [FUNC-1:0] OP_ADD   = FUNC'(0);
  localparam logic [FUNC-1:0] OP_SUB   = FUNC'(1);
  localparam logic [FUNC-1:0] OP_MUL   = FUNC'(2);
  localparam logic [FUNC-1:0] OP_DIV   = FUNC'(3);
  localparam logic [FUNC-1:0] OP_AND   = FUNC'(4);
  localparam logic [FUNC-1:0] OP_OR    = FUNC'(5);
  localparam logic [FUNC-1:0] OP_NAND  = FUNC'(6);
  localparam logic [FUNC-1:0] OP_NOR   = FUNC'(7);
  localparam logic [FUNC-1:0] OP_XOR   = FUNC'(8);
  localparam logic [FUNC-1:0] OP_XNOR  = FUNC'(9);
  localparam logic [FUNC-1:0] OP_CMPEQ = FUNC'(10);
  localparam logic [FUNC-1:0] OP_CMPGT = FUNC'(11);
  localparam logic [FUNC-1:0] OP_CMPLT = FUNC'(12);
  localparam logic [FUNC-1:0] OP_SHL   = FUNC'(13);
  localparam logic [FUNC-1:0] OP_SHR   = FUNC'(14);
  localparam logic [FUNC-1:0] OP_MOD   = FUNC'(15);

  // Single-cycle result path
  logic [W-1:0]  and_w, or_w, xor_w, nand_w, nor_w, xnor_w;
  logic [W:0]    sum_w, diff_w;
  logic [OW-1:0] fast_res;
  logic          fast_err;

  always_comb begin
    and_w    = A & B;
    or_w     = A | B;
    xor_w    = A ^ B;
    nand_w   = ~and_w;
    nor_w    = ~or_w;
    xnor_w   = ~xor_w;
    sum_w    = {1'b0, A} + {1'b0, B};
    // W+1 bit difference: bit W ends up as the borrow
    diff_w   = {1'b0, A} - {1'b0, B};
    fast_res = '0;
    fast_err = 1'b0;
    case (ALU_FUNC)
      OP_ADD:   fast_res = OW'(sum_w);
      OP_SUB:   fast_res = OW'(diff_w);
      OP_MUL:   fast_res = OW'(A) * OW'(B);
      OP_AND:   fast_res = OW'(and_w);
      OP_OR:    fast_res = OW'(or_w);
      OP_NAND:  fast_res = OW'(nand_w);
      OP_NOR:   fast_res = OW'(nor_w);
      OP_XOR:   fast_res = OW'(xor_w);
      OP_XNOR:  fast_res = OW'(xnor_w);
      OP_CMPEQ: fast_res = (A == B) ? OW'(1) : '0;
      OP_CMPGT: fast_res = (A > B)  ? OW'(2) : '0;
      OP_CMPLT: fast_res = (A < B)  ? OW'(3) : '0;
      OP_SHL:   fast_res = OW'({A, 1'b0});
      OP_SHR:   fast_res = OW'(A >> 1);
      // Only reached here with B=0 when the divider exists; otherwise always an error
      OP_DIV: begin
        fast_err = 1'b1;
`ifdef ALU_DIV_EN
        fast_res = OW'({W{1'b1}});
`endif
      end
      OP_MOD: begin
        fast_err = 1'b1;
`ifdef ALU_DIV_EN
        fast_res = OW'(A);
`endif
      end
      default: fast_res = '0;
    endcase
  end

  logic          start;     // accepted DIV/MOD that needs the iterative divider
  logic          div_done;  // last divider iteration this cycle
  logic [OW-1:0] div_res;

`ifdef ALU_DIV_EN
  typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;
  localparam int CW = $clog2(W);

  state_t        state, state_nxt;
  logic [W-1:0]  dvd_q, dvs_q, rem_q, quo_q;
  logic [CW-1:0] cnt_q;
  logic          mod_q;
  logic          is_div;
  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  rem_it, quo_it;
  logic          last;

  // One restoring step: shift next dividend bit into the partial remainder
  always_comb begin
    trial  = {rem_q, dvd_q[W-1]};
    ge     = (trial >= {1'b0, dvs_q});
    rem_it = ge ? W'(trial - {1'b0, dvs_q}) : trial[W-1:0];
    quo_it = {quo_q[W-2:0], ge};
    last   = (cnt_q == CW'(W - 1));
  end

  assign is_div   = (ALU_FUNC == OP_DIV) || (ALU_FUNC == OP_MOD);
  assign start    = Enable && (state == S_IDLE) && is_div && (B != '0);
  assign Busy     = (state == S_DIV);
  assign div_done = (state == S_DIV) && last;
  assign div_res  = mod_q ? OW'(rem_it) : OW'(quo_it);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_DIV;
      S_DIV:  if (last)  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      mod_q <= 1'b0;
    end else if (start) begin
      dvd_q <= A;
      dvs_q <= B;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      mod_q <= (ALU_FUNC == OP_MOD);
    end else if (state == S_DIV) begin
      dvd_q <= {dvd_q[W-2:0], 1'b0};
      rem_q <= rem_it;
      quo_q <= quo_it;
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  assign start    = 1'b0;
  assign Busy     = 1'b0;
  assign div_done = 1'b0;
  assign div_res  = '0;
`endif

  // Output next-value logic; Busy gates new requests, divider completion wins
  logic [OW-1:0] out_nxt;
  logic          vld_nxt, err_nxt;

  always_comb begin
    out_nxt = ALU_OUT;
    vld_nxt = 1'b0;
    err_nxt = DIV_ERR;
    if (div_done) begin
      out_nxt = div_res;
      vld_nxt = 1'b1;
      err_nxt = 1'b0;
    end else if (Enable && !Busy && !start) begin
      out_nxt = fast_res;
      vld_nxt = 1'b1;
      err_nxt = fast_err;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_OUT   <= '0;
      OUT_VALID <= 1'b0;
      DIV_ERR   <= 1'b0;
    end else begin
      ALU_OUT   <= out_nxt;
      OUT_VALID <= vld_nxt;
      DIV_ERR   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [W-1:0]  A, B;
  logic [3:0]    ALU_FUNC;
  logic          Enable;
  logic          Busy;
  logic [15:0]   ALU_OUT;
  logic          OUT_VALID;
  logic          DIV_ERR;

  alu_seq #(.DATAWIDTH(W), .FUNC(4)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUNC(ALU_FUNC), .Enable(Enable),
    .Busy(Busy), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .DIV_ERR(DIV_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int          lat;
    logic        err;
    logic [15:0] out;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    e.lat = 1;
    e.err = 1'b0;
    e.out = 16'h0;
    case (op)
      4'd0:  e.out = 16'(ai + bi);
      4'd1:  e.out = 16'((ai - bi) & 'h1FF);
      4'd2:  e.out = 16'(ai * bi);
      4'd4:  e.out = 16'(ai & bi);
      4'd5:  e.out = 16'(ai | bi);
      4'd6:  e.out = 16'(~(ai & bi) & 'hFF);
      4'd7:  e.out = 16'(~(ai | bi) & 'hFF);
      4'd8:  e.out = 16'(ai ^ bi);
      4'd9:  e.out = 16'(~(ai ^ bi) & 'hFF);
      4'd10: e.out = (ai == bi) ? 16'd1 : 16'd0;
      4'd11: e.out = (ai > bi)  ? 16'd2 : 16'd0;
      4'd12: e.out = (ai < bi)  ? 16'd3 : 16'd0;
      4'd13: e.out = 16'(ai * 2);
      4'd14: e.out = 16'(ai / 2);
      default: begin // DIV (3) and MOD (15)
        if (!DIV_EN) begin
          e.err = 1'b1;
          e.out = 16'h0;
        end else if (bi == 0) begin
          e.err = 1'b1;
          e.out = (op == 4'd3) ? 16'h00FF : 16'(ai);
        end else begin
          e.lat = W + 1;
          e.out = (op == 4'd3) ? 16'(ai / bi) : 16'(ai % bi);
        end
      end
    endcase
    return e;
  endfunction

  // Issue one op, wait (bounded) for the pulse, compare against the scoreboard.
  // With inject set, an ADD 1+1 request is pulsed while the DUT is busy.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit inject, input string tag);
    exp_t e;
    int lat, busy_cnt, extra;
    @(negedge CLK);
    ALU_FUNC = op; A = a; B = b; Enable = 1'b1;
    sb.push_back(model(op, a, b));
    @(negedge CLK);
    Enable = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (OUT_VALID !== 1'b1 && lat < 40) begin
      if (Busy === 1'b1) busy_cnt++;
      if (inject && lat == 3) begin
        ALU_FUNC = 4'd0; A = 8'd1; B = 8'd1; Enable = 1'b1;
      end else begin
        Enable = 1'b0;
      end
      @(negedge CLK);
      lat++;
    end
    Enable = 1'b0;
    e = sb.pop_front();
    check({tag, "_valid"},   32'(OUT_VALID), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_busycyc"}, 32'(busy_cnt), 32'(e.lat - 1));
    check({tag, "_busy_at_valid"}, 32'(Busy), 32'd0);
    check({tag, "_out"},     32'(ALU_OUT), 32'(e.out));
    check({tag, "_err"},     32'(DIV_ERR), 32'(e.err));
    @(negedge CLK);
    check({tag, "_pulse_end"}, 32'(OUT_VALID), 32'd0);
    check({tag, "_hold"},      32'(ALU_OUT), 32'(e.out));
    if (inject) begin
      extra = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge CLK);
        if (OUT_VALID === 1'b1) extra++;
      end
      check({tag, "_no_extra_pulse"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    int pulses, busy_seen;

    RST = 1'b0; Enable = 1'b0; A = '0; B = '0; ALU_FUNC = '0;
    #1;
    check("rst_out",   32'(ALU_OUT),   32'd0);
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_busy",  32'(Busy),      32'd0);
    check("rst_err",   32'(DIV_ERR),   32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    run_op(4'd0,  8'hFF, 8'h01, 1'b0, "add_carry");
    run_op(4'd2,  8'hFF, 8'hFF, 1'b0, "mul_max");
    run_op(4'd3,  8'd200, 8'd7, 1'b0, "div_200_7");
    run_op(4'd15, 8'd200, 8'd7, 1'b0, "mod_200_7");
    run_op(4'd3,  8'd200, 8'd7, 1'b1, "div_inject");
    run_op(4'd3,  8'hFF, 8'h01, 1'b0, "div_by_one");
    run_op(4'd15, 8'd5,  8'd9,  1'b0, "mod_small");
    run_op(4'd1,  8'd3,  8'd5,  1'b0, "sub_borrow");
    run_op(4'd4,  8'hC3, 8'h5A, 1'b0, "and");
    run_op(4'd5,  8'hC3, 8'h5A, 1'b0, "or");
    run_op(4'd6,  8'hC3, 8'h5A, 1'b0, "nand");
    run_op(4'd7,  8'hC3, 8'h5A, 1'b0, "nor");
    run_op(4'd9,  8'hC3, 8'h5A, 1'b0, "xnor");
    run_op(4'd10, 8'h42, 8'h42, 1'b0, "cmpeq");
    run_op(4'd11, 8'h80, 8'h7F, 1'b0, "cmpgt");
    run_op(4'd12, 8'h80, 8'h7F, 1'b0, "cmplt_false");
    run_op(4'd13, 8'h81, 8'h00, 1'b0, "shl");
    run_op(4'd14, 8'h81, 8'h00, 1'b0, "shr");
    run_op(4'd3,  8'h55, 8'h00, 1'b0, "div_by_zero");
    run_op(4'd0,  8'h01, 8'h01, 1'b0, "add_clears_err");
    run_op(4'd15, 8'h37, 8'h00, 1'b0, "mod_by_zero");

    // Back-to-back requests: one result per cycle
    @(negedge CLK);
    ALU_FUNC = 4'd0; A = 8'd10; B = 8'd20; Enable = 1'b1;
    sb.push_back(model(4'd0, 8'd10, 8'd20));
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      e = sb.pop_front();
      check("b2b_valid", 32'(OUT_VALID), 32'd1);
      check("b2b_out",   32'(ALU_OUT),   32'(e.out));
      if (i == 1) begin
        ALU_FUNC = 4'd1; A = 8'd3; B = 8'd5;
        sb.push_back(model(4'd1, 8'd3, 8'd5));
      end else if (i == 2) begin
        ALU_FUNC = 4'd8; A = 8'hC3; B = 8'h5A;
        sb.push_back(model(4'd8, 8'hC3, 8'h5A));
      end else begin
        Enable = 1'b0;
      end
    end

    // Reset in the middle of a division: immediate clear, no late pulse
    @(negedge CLK);
    ALU_FUNC = 4'd3; A = 8'd200; B = 8'd7; Enable = 1'b1;
    @(negedge CLK);
    Enable = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("midrst_out",   32'(ALU_OUT),   32'd0);
    check("midrst_valid", 32'(OUT_VALID), 32'd0);
    check("midrst_busy",  32'(Busy),      32'd0);
    check("midrst_err",   32'(DIV_ERR),   32'd0);
    @(negedge CLK);
    RST = 1'b1;
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) pulses++;
      if (Busy === 1'b1) busy_seen++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    check("midrst_no_busy",  32'(busy_seen), 32'd0);

    run_op(4'd0, 8'hFF, 8'h01, 1'b0, "add_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
